// File: rtl/agc_timing_pkg.sv
// Shared AGC timing definitions: time-pulse count, sequencer states, one-hot helper.
package agc_timing_pkg;
  localparam int TP_COUNT = 12;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    STEP  = 2'd2
  } tpg_state_e;

  function automatic logic [TP_COUNT:1] tp_onehot(input logic [3:0] tp);
    tp_onehot = TP_COUNT'(1) << (tp - 4'd1);
  endfunction
endpackage

// File: rtl/time_pulse_gen_if.sv
// Time pulse generator control/status bundle; the sequencer sits on the slave side.
interface time_pulse_gen_if;
  import agc_timing_pkg::*;
  logic                STRT2;
  logic                STOP_;
  logic [TP_COUNT:1]   T;
  logic [TP_COUNT:1]   T_;
  logic                PHS2_;
  logic                PHS4_;
  logic                GOJAM;
  logic                STOPPED;

  modport master (output STRT2, STOP_, input T, T_, PHS2_, PHS4_, GOJAM, STOPPED);
  modport slave  (input STRT2, STOP_, output T, T_, PHS2_, PHS4_, GOJAM, STOPPED);
endinterface

// File: rtl/tpg_step_sync.sv
// MSTEP two-flop synchronizer plus rising-edge detect (built only with TPG_SINGLE_STEP_EN).
module tpg_step_sync (
  input  logic CLOCK,
  input  logic rst_,
  input  logic MSTEP,
  output logic step_rise
);
  // sh[1:0] is the synchronizer, sh[2] holds the previous synchronized level
  logic [2:0] sh;

  always_ff @(posedge CLOCK or negedge rst_) begin
    if (!rst_) sh <= '0;
    else       sh <= {sh[1:0], MSTEP};
  end

  assign step_rise = sh[1] & ~sh[2];
endmodule

// File: rtl/time_pulse_gen.sv
// AGC time pulse sequencer: T01..T12 ring, phase strobes, GOJAM and stop/stall control.
// Define TPG_SINGLE_STEP_EN to add the MSTEP input and the single-MCT STEP state.
module time_pulse_gen
  import agc_timing_pkg::*;
#(
  parameter int DIV = 2
) (
  input  logic CLOCK,
  input  logic rst_,
`ifdef TPG_SINGLE_STEP_EN
  input  logic MSTEP,
`endif
  time_pulse_gen_if.slave tp_bus
);
  localparam int              PH_W    = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(DIV - 1);
  localparam logic [3:0]      TP_LAST = 4'(TP_COUNT);

  logic [3:0]        tp, tp_n;
  logic [PH_W-1:0]   ph, ph_n;
  tpg_state_e        state, state_n;
  logic              wrap, gojam_n, run_n;
  logic              gojam_q, stopped_q, phs2_q, phs4_q;
  logic [TP_COUNT:1] t_q, tn_q;

`ifdef TPG_SINGLE_STEP_EN
  logic step_rise;

  tpg_step_sync u_step_sync (
    .CLOCK     (CLOCK),
    .rst_      (rst_),
    .MSTEP     (MSTEP),
    .step_rise (step_rise)
  );
`endif

  // STEP sequences exactly like RUN; only the way it is entered differs.
  // A stall is left on any clock that samples STOP_=1 or STRT2=1.
  always_comb begin
    state_n = state;
    tp_n    = tp;
    ph_n    = ph;
    wrap    = 1'b0;
    if (state == STALL) begin
      if (tp_bus.STRT2 || tp_bus.STOP_) begin
        state_n = RUN;
        wrap    = 1'b1;
      end
`ifdef TPG_SINGLE_STEP_EN
      else if (step_rise) begin
        state_n = STEP;
        wrap    = 1'b1;
      end
`endif
    end else if (ph != PH_LAST) begin
      ph_n = ph + 1'b1;
    end else if (tp != TP_LAST) begin
      tp_n = tp + 4'd1;
      ph_n = '0;
    end else if (!tp_bus.STOP_) begin
      state_n = STALL;
    end else begin
      state_n = RUN;
      wrap    = 1'b1;
    end
    if (wrap) begin
      tp_n = 4'd1;
      ph_n = '0;
    end
    gojam_n = tp_bus.STRT2 | (gojam_q & ~wrap);
    run_n   = (state_n != STALL);
  end

  // Outputs are registered from next-state values so every pin comes off a flop
  always_ff @(posedge CLOCK or negedge rst_) begin
    if (!rst_) begin
      state     <= RUN;
      tp        <= TP_LAST;
      ph        <= PH_LAST;
      gojam_q   <= 1'b1;
      stopped_q <= 1'b0;
      t_q       <= tp_onehot(TP_LAST);
      tn_q      <= ~tp_onehot(TP_LAST);
      phs2_q    <= 1'b1;
      phs4_q    <= 1'b0;
    end else begin
      state     <= state_n;
      tp        <= tp_n;
      ph        <= ph_n;
      gojam_q   <= gojam_n;
      stopped_q <= ~run_n;
      t_q       <= tp_onehot(tp_n);
      tn_q      <= ~tp_onehot(tp_n);
      phs2_q    <= ~(run_n && (ph_n == '0));
      phs4_q    <= ~(run_n && (ph_n == PH_LAST));
    end
  end

  assign tp_bus.T       = t_q;
  assign tp_bus.T_      = tn_q;
  assign tp_bus.PHS2_   = phs2_q;
  assign tp_bus.PHS4_   = phs4_q;
  assign tp_bus.GOJAM   = gojam_q;
  assign tp_bus.STOPPED = stopped_q;
endmodule

// File: tb/tb_time_pulse_gen.sv
// Scoreboard bench for time_pulse_gen (DIV=2); step scenario runs when TPG_SINGLE_STEP_EN is defined.
module tb_time_pulse_gen;
  import agc_timing_pkg::*;

  typedef struct {
    logic [12:1] t;
    logic        phs2_;
    logic        phs4_;
    logic        gojam;
    logic        stopped;
  } exp_t;

  logic CLOCK = 1'b0;
  logic rst_  = 1'b1;
`ifdef TPG_SINGLE_STEP_EN
  logic MSTEP = 1'b0;
`endif

  time_pulse_gen_if tpb ();

  time_pulse_gen #(.DIV(2)) dut (
    .CLOCK  (CLOCK),
    .rst_   (rst_),
`ifdef TPG_SINGLE_STEP_EN
    .MSTEP  (MSTEP),
`endif
    .tp_bus (tpb)
  );

  always #5 CLOCK = ~CLOCK;

  int   n_chk = 0;
  int   n_err = 0;
  exp_t sb[$];

  // Reference: position 0..23 within the MCT (tp = pos/2+1, ph = pos%2)
  int       m_pos;
  bit       m_stall, m_gojam;
  bit [2:0] m_ms;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic m_reset();
    m_pos = 23; m_stall = 0; m_gojam = 1; m_ms = '0;
  endtask

  task automatic m_edge(input bit strt2, input bit stop_, input bit mstep);
    bit rise;
    rise = m_ms[1] & ~m_ms[2];
    m_ms = {m_ms[1:0], mstep};
    if (m_stall) begin
      if (strt2 || stop_ || rise) begin
        m_stall = 0; m_pos = 0; m_gojam = strt2;
      end else m_gojam |= strt2;
    end else if (m_pos == 23) begin
      if (stop_) begin m_pos = 0; m_gojam = strt2; end
      else begin m_stall = 1; m_gojam |= strt2; end
    end else begin
      m_pos++; m_gojam |= strt2;
    end
  endtask

  function automatic exp_t m_expect();
    exp_t e;
    e.t       = 12'(1) << (m_pos / 2);
    e.phs2_   = m_stall || (m_pos % 2 != 0);
    e.phs4_   = m_stall || (m_pos % 2 != 1);
    e.gojam   = m_gojam;
    e.stopped = m_stall;
    return e;
  endfunction

  // One clock of stimulus; the expected post-edge outputs go to the scoreboard
  task automatic drive(input bit rst, input bit strt2, input bit stop_, input bit mstep);
    bit was_rst;
    @(negedge CLOCK);
    #1;
    was_rst   = rst_;
    tpb.STRT2 = strt2;
    tpb.STOP_ = stop_;
`ifdef TPG_SINGLE_STEP_EN
    MSTEP = mstep;
`endif
    rst_ = rst;
    if (!rst) begin
      m_reset();
      if (was_rst) begin
        #1;
        chk("rst_T",       32'(tpb.T),       32'h800);
        chk("rst_T_",      32'(tpb.T_),      32'h7ff);
        chk("rst_PHS2_",   32'(tpb.PHS2_),   32'd1);
        chk("rst_PHS4_",   32'(tpb.PHS4_),   32'd0);
        chk("rst_GOJAM",   32'(tpb.GOJAM),   32'd1);
        chk("rst_STOPPED", 32'(tpb.STOPPED), 32'd0);
      end
    end else m_edge(strt2, stop_, mstep);
    sb.push_back(m_expect());
  endtask

  always @(negedge CLOCK) begin
    if (sb.size() != 0) begin
      exp_t        e;
      logic [12:1] nt;
      e  = sb.pop_front();
      nt = ~e.t;
      chk("T",       32'(tpb.T),       32'(e.t));
      chk("T_",      32'(tpb.T_),      32'(nt));
      chk("PHS2_",   32'(tpb.PHS2_),   32'(e.phs2_));
      chk("PHS4_",   32'(tpb.PHS4_),   32'(e.phs4_));
      chk("GOJAM",   32'(tpb.GOJAM),   32'(e.gojam));
      chk("STOPPED", 32'(tpb.STOPPED), 32'(e.stopped));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", n_chk, n_err);
    $fatal(1, "timeout");
  end

  initial begin
    tpb.STRT2 = 1'b0;
    tpb.STOP_ = 1'b1;
    m_reset();
    #2;
    repeat (3) drive(0, 0, 1, 0);
    // release: T01..T12 at two clocks each, then T01 again
    repeat (26) drive(1, 0, 1, 0);
    // one-clock STRT2 at T05; GOJAM holds until the next T12->T01
    for (int i = 0; i < 40 && m_pos != 8; i++) drive(1, 0, 1, 0);
    drive(1, 1, 1, 0);
    repeat (30) drive(1, 0, 1, 0);
    // STOP_ low before end of T12 -> stall, then resume
    for (int i = 0; i < 40 && m_pos != 20; i++) drive(1, 0, 1, 0);
    repeat (7) drive(1, 0, 0, 0);
    repeat (4) drive(1, 0, 1, 0);
    // STRT2 and STOP_=0 together at end of T12, STRT2 also releases the stall
    for (int i = 0; i < 40 && m_pos != 23; i++) drive(1, 0, 1, 0);
    drive(1, 1, 0, 0);
    drive(1, 1, 0, 0);
    repeat (30) drive(1, 0, 1, 0);
`ifdef TPG_SINGLE_STEP_EN
    // MSTEP edge while running is ignored; one edge in stall runs one MCT
    drive(1, 0, 1, 1);
    repeat (3) drive(1, 0, 1, 0);
    for (int i = 0; i < 40 && m_pos != 23; i++) drive(1, 0, 1, 0);
    repeat (3) drive(1, 0, 0, 0);
    repeat (3) drive(1, 0, 0, 1);
    repeat (30) drive(1, 0, 0, 1);
    repeat (3) drive(1, 0, 1, 0);
`endif
    // asynchronous reset at T07 ph=1, then recovery
    for (int i = 0; i < 40 && m_pos != 13; i++) drive(1, 0, 1, 0);
    drive(0, 0, 1, 0);
    repeat (2) drive(0, 0, 1, 0);
    repeat (8) drive(1, 0, 1, 0);
    @(negedge CLOCK);
    #1;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
